// File: rtl/div_iter32_if.sv
// Request/result bundle between the execute-stage controller and the iterative divider.
interface div_iter32_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dz;

  modport master (
    output start, is_signed, dividend, divisor,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output q, r, busy, done, dz
  );
endinterface

// File: rtl/div_iter32.sv
// Restoring 32-bit divider, one quotient bit per cycle: done 33 cycles after start, busy blocks new starts.
// `DIV_ZERO_FAST_EN: zero divisor bypasses the iteration (done 1 cycle after load) and raises dz.
module div_iter32 (
  input  logic        clk,
  input  logic        rstn,
  div_iter32_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dmag_q, dmag_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        done_q, done_d;

  logic        load_en, step_en, fix_en;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, trial;

`ifdef DIV_ZERO_FAST_EN
  logic div_zero;
  logic zflag_q, zflag_d;
  logic dz_q, dz_d;
  assign div_zero = (bus.divisor == 32'd0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dmag_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      zflag_q   <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dmag_q    <= dmag_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      q_q       <= q_d;
      r_q       <= r_d;
      done_q    <= done_d;
`ifdef DIV_ZERO_FAST_EN
      zflag_q   <= zflag_d;
      dz_q      <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = div_zero ? FIX : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en = (state_q == IDLE) && bus.start;
    step_en = (state_q == RUN);
    fix_en  = (state_q == FIX);
  end

  // Quotient register doubles as the dividend shifter: MSBs leave as quotient bits enter at the LSB.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dmag_d    = dmag_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    q_d       = q_q;
    r_d       = r_q;
    done_d    = fix_en;
`ifdef DIV_ZERO_FAST_EN
    zflag_d   = zflag_q;
    dz_d      = dz_q;
`endif
    a_mag   = (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
    b_mag   = (bus.is_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dmag_q};

    if (load_en) begin
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = a_mag;
      dmag_d    = b_mag;
      neg_quo_d = bus.is_signed && (bus.dividend[31] ^ bus.divisor[31]);
      neg_rem_d = bus.is_signed && bus.dividend[31];
`ifdef DIV_ZERO_FAST_EN
      zflag_d   = div_zero;
      if (div_zero) begin
        quo_d = '1;
        rem_d = a_mag;
      end
`endif
    end else if (step_en) begin
      cnt_d = cnt_q + 5'd1;
      // A set borrow bit means the trial went negative, so the shifted value is restored.
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end else if (fix_en) begin
      q_d = neg_quo_q ? -quo_q : quo_q;
      r_d = neg_rem_q ? -rem_q : rem_q;
`ifdef DIV_ZERO_FAST_EN
      dz_d = zflag_q;
`endif
    end
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
`ifdef DIV_ZERO_FAST_EN
  assign bus.dz   = dz_q;
`else
  assign bus.dz   = 1'b0;
`endif

endmodule

// File: tb/tb_div_iter32.sv
// Randomized and directed stimulus for div_iter32; a queue-based scoreboard checks every done pulse.
module tb_div_iter32;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_iter32_if dif ();

  div_iter32 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          e0;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero, done in 64 bits.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb2;
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      q   = 32'(sa / sb2);
      r   = 32'(sa % sb2);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int   n = 0;
    exp_t e;
    while (dif.busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout busy still %b after %0d cycles", dif.busy, n);
    end
    e.a = a;
    e.b = b;
    ref_div(a, b, s, e.q, e.r);
`ifdef DIV_ZERO_FAST_EN
    e.dz  = (b == 32'd0);
    e.lat = (b == 32'd0) ? 1 : 33;
`else
    e.dz  = 1'b0;
    e.lat = 33;
`endif
    e.e0 = cyc + 1;
    dif.start     = 1'b1;
    dif.is_signed = s;
    dif.dividend  = a;
    dif.divisor   = b;
    sb.push_back(e);
    step();
    dif.start     = 1'b0;
    dif.is_signed = 1'($urandom_range(0, 1));
    dif.dividend  = $urandom;
    dif.divisor   = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout %0d results outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: consumes one expectation per done pulse.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (dif.done === 1'b1) begin
        chk("done_single_cycle", {31'b0, prev}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done q %h r %h, required no result", dif.q, dif.r);
        end else begin
          e = sb.pop_front();
          chk($sformatf("q %h/%h", e.a, e.b), dif.q, e.q);
          chk($sformatf("r %h/%h", e.a, e.b), dif.r, e.r);
          chk($sformatf("dz %h/%h", e.a, e.b), {31'b0, dif.dz}, {31'b0, e.dz});
          chk($sformatf("latency %h/%h", e.a, e.b), 32'(cyc - e.e0), 32'(e.lat));
        end
      end
      prev = dif.done;
    end
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          sel;

    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("reset_q", dif.q, 32'd0);
    chk("reset_r", dif.r, 32'd0);
    chk("reset_busy", {31'b0, dif.busy}, 32'd0);
    chk("reset_done", {31'b0, dif.done}, 32'd0);
    chk("reset_dz", {31'b0, dif.dz}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // 100/7: busy for exactly the 33 cycles before done
    run_op(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 33; i++) begin
      chk($sformatf("busy_cycle_%0d", i + 1), {31'b0, dif.busy}, 32'd1);
      chk($sformatf("no_done_cycle_%0d", i + 1), {31'b0, dif.done}, 32'd0);
      step();
    end
    chk("busy_in_done_cycle", {31'b0, dif.busy}, 32'd0);
    chk("done_after_33", {31'b0, dif.done}, 32'd1);
    chk("q_100_7", dif.q, 32'd14);
    chk("r_100_7", dif.r, 32'd2);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h1234_5678, 32'd0, 1'b0);
    run_op(32'h8765_4321, 32'd0, 1'b1);
    wait_drain();

    // Start while busy must be ignored; the follow-up lands in the done cycle
    run_op(32'd9, 32'd3, 1'b0);
    repeat (9) step();
    dif.start    = 1'b1;
    dif.dividend = 32'd50;
    dif.divisor  = 32'd5;
    step();
    dif.start = 1'b0;
    run_op(32'd50, 32'd5, 1'b0);
    wait_drain();
    repeat (40) step();

    // Asynchronous reset in the middle of an operation
    run_op(32'd1000, 32'd3, 1'b0);
    repeat (14) step();
    #2 rstn = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, dif.busy}, 32'd0);
    chk("midreset_done", {31'b0, dif.done}, 32'd0);
    chk("midreset_q", dif.q, 32'd0);
    chk("midreset_r", dif.r, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    step();
    run_op(32'd1000, 32'd3, 1'b0);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s);
    end
    wait_drain();
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
